mxu_feeder: RTL and testbench

Upstream feeder for the systolic matrix unit. It accepts operand matrices A and B one row per beat over a valid/ready handshake and holds them in an internal buffer. It then streams them into the array's west and north lanes with the diagonal skew the array needs: row r is delayed r cycles and column c is delayed c cycles. It drives the array clock-enable and pulses `done` when the array holds the complete product C = A·B.

---
 rtl/mxu_feeder.sv | 166 ++++++++++++++++
 tb/tb_mxu_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_feeder.sv
// mxu_feeder: upstream feeder for a GRID_SIZE x GRID_SIZE systolic matrix unit.
// Captures matrices A and B one row per beat over a valid/ready handshake, then
// streams them into the array with diagonal skew (west lane r delayed r cycles,
// north lane c delayed c cycles), drives the array clock-enable and pulses done.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   beat on in_a/in_b is valid
//   in_ready   out  block accepts a beat (high in LOAD only)
//   in_a       in   row k of A, lane j = element A[k][j]
//   in_b       in   row k of B, same lane packing
//   hold       in   stall request while streaming
//   west_out   out  west lanes, lane r carries row r of A (registered)
//   north_out  out  north lanes, lane c carries column c of B (registered)
//   mxu_ce     out  array clock-enable (registered)
//   done       out  one-cycle pulse when streaming completes (registered)
module mxu_feeder #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_SIZE*GRID_SIZE-1:0] in_a,
    input  logic [NUM_SIZE*GRID_SIZE-1:0] in_b,
    input  logic                          hold,
    output logic [NUM_SIZE*GRID_SIZE-1:0] west_out,
    output logic [NUM_SIZE*GRID_SIZE-1:0] north_out,
    output logic                          mxu_ce,
    output logic                          done
);

    localparam int G  = GRID_SIZE;
    localparam int S  = 3 * G - 2;
    localparam int BW = $clog2(G + 1);
    localparam int TW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [BW-1:0]             beat_cnt;
    logic [BW-1:0]             beat_cnt_next;
    logic [TW-1:0]             t;
    logic [TW-1:0]             t_next;
    logic [NUM_SIZE*G-1:0]     west_next;
    logic [NUM_SIZE*G-1:0]     north_next;
    logic                      ce_next;
    logic                      done_next;
    logic                      accept;

    // Operand buffer; contents are don't-care after reset, so no reset here.
    logic [NUM_SIZE-1:0]       buf_a [G][G];
    logic [NUM_SIZE-1:0]       buf_b [G][G];

    assign in_ready = (state == LOAD);
    assign accept   = in_valid & in_ready;

    // Capture an accepted beat into buffer row beat_cnt.
    always_ff @(posedge clk) begin
        for (int r = 0; r < G; r++) begin
            if (accept && (beat_cnt == BW'(r))) begin
                for (int j = 0; j < G; j++) begin
                    buf_a[r][j] <= in_a[j*NUM_SIZE +: NUM_SIZE];
                    buf_b[r][j] <= in_b[j*NUM_SIZE +: NUM_SIZE];
                end
            end
        end
    end

    // Next-state, counter and output-register decode.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        t_next        = t;
        west_next     = '0;
        north_next    = '0;
        ce_next       = 1'b0;
        done_next     = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (beat_cnt == BW'(G - 1)) begin
                        beat_cnt_next = '0;
                        t_next        = '0;
                        state_next    = STREAM;
                    end else begin
                        beat_cnt_next = beat_cnt + BW'(1);
                    end
                end else begin
                    beat_cnt_next = beat_cnt;
                end
            end
            STREAM: begin
                if (hold) begin
                    // Freeze the lanes; the step is neither dropped nor repeated.
                    west_next  = west_out;
                    north_next = north_out;
                end else begin
                    ce_next = 1'b1;
                    // Element (r,j) of A enters west lane r at step r+j;
                    // element (i,c) of B enters north lane c at step i+c.
                    for (int r = 0; r < G; r++) begin
                        for (int j = 0; j < G; j++) begin
                            if ((r + j) == int'(t)) begin
                                west_next[r*NUM_SIZE +: NUM_SIZE]  = buf_a[r][j];
                            end
                            if ((r + j) == int'(t)) begin
                                north_next[j*NUM_SIZE +: NUM_SIZE] = buf_b[r][j];
                            end
                        end
                    end
                    if (t == TW'(S - 1)) begin
                        t_next     = '0;
                        state_next = DONE;
                    end else begin
                        t_next = t + TW'(1);
                    end
                end
            end
            DONE: begin
                // First DONE cycle raises done; the second returns to LOAD.
                if (!done) begin
                    done_next = 1'b1;
                end else begin
                    beat_cnt_next = '0;
                    t_next        = '0;
                    state_next    = LOAD;
                end
            end
            default: begin
                beat_cnt_next = '0;
                t_next        = '0;
                state_next    = LOAD;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            beat_cnt  <= '0;
            t         <= '0;
            west_out  <= '0;
            north_out <= '0;
            mxu_ce    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            beat_cnt  <= beat_cnt_next;
            t         <= t_next;
            west_out  <= west_next;
            north_out <= north_next;
            mxu_ce    <= ce_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_mxu_feeder.sv
// Self-checking bench for mxu_feeder (G=2, 16-bit elements). A behavioural
// timeline model derives, cycle by cycle after the last accepted beat, the
// expected lanes / mxu_ce / done / in_ready from the matrices and hold pattern.
module tb_mxu_feeder;

    localparam int N    = 16;
    localparam int G    = 2;
    localparam int S    = 3 * G - 2;
    localparam int NCYC = 16;
    localparam int OW   = 2 * N * G + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*G-1:0]    in_a;
    logic [N*G-1:0]    in_b;
    logic              hold;
    logic [N*G-1:0]    west_out;
    logic [N*G-1:0]    north_out;
    logic              mxu_ce;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0]  ma [G][G];
    logic [N-1:0]  mb [G][G];
    bit            hold_pat [NCYC];
    logic [OW-1:0] obs  [NCYC];   // {west, north, mxu_ce, done, in_ready}
    logic [OW-1:0] expv [NCYC];

    mxu_feeder #(.NUM_SIZE(N), .GRID_SIZE(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .hold      (hold),
        .west_out  (west_out),
        .north_out (north_out),
        .mxu_ce    (mxu_ce),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected observation for cycle i after the last beat edge.
    task automatic model_job();
        logic [N*G-1:0] w;
        logic [N*G-1:0] n;
        int k;
        int done_at;
        w = '0; n = '0; k = 0; done_at = -1;
        for (int i = 0; i < NCYC; i++) begin
            if (k < S) begin
                if (!hold_pat[i]) begin
                    w = '0; n = '0;
                    for (int r = 0; r < G; r++)
                        if (k - r >= 0 && k - r < G) w[r*N +: N] = ma[r][k-r];
                    for (int c = 0; c < G; c++)
                        if (k - c >= 0 && k - c < G) n[c*N +: N] = mb[k-c][c];
                    k++;
                    expv[i] = {w, n, 3'b100};
                end else begin
                    expv[i] = {w, n, 3'b000};
                end
            end else if (done_at < 0) begin
                done_at = i;
                expv[i] = {{(2*N*G){1'b0}}, 3'b010};
            end else begin
                expv[i] = {{(2*N*G){1'b0}}, 3'b001};
            end
        end
    endtask

    // Drive the G rows of ma/mb with up to max_bubble idle cycles before each.
    task automatic load_job(input int max_bubble, input bit keep_valid);
        for (int k = 0; k < G; k++) begin
            repeat ($urandom_range(max_bubble, 0)) begin
                in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            for (int j = 0; j < G; j++) begin
                in_a[j*N +: N] = ma[k][j];
                in_b[j*N +: N] = mb[k][j];
            end
            @(posedge clk); #1;
        end
        if (keep_valid) begin
            in_a = $urandom; in_b = $urandom;   // junk that must not be captured
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Apply the hold pattern and record outputs for ncyc cycles.
    task automatic run_stream(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            hold = hold_pat[i];
            @(posedge clk); #1;
            obs[i] = {west_out, north_out, mxu_ce, done, in_ready};
            if (done) in_valid = 1'b0;
        end
        hold = 1'b0;
    endtask

    task automatic set_basic();
        ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
        mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
        for (int i = 0; i < NCYC; i++) hold_pat[i] = 1'b0;
    endtask

    task automatic test_reset();
        set_basic();
        load_job(0, 0);
        run_stream(2);
        #2 rst = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        vectors++; if (west_out !== '0) begin miscompares++; $display("FAIL reset_west got %h exp 0", west_out); end
        vectors++; if (north_out !== '0) begin miscompares++; $display("FAIL reset_north got %h exp 0", north_out); end
        vectors++; if (mxu_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce got %b exp 0", mxu_ce); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [N*G-1:0] tw [S];
        logic [N*G-1:0] tn [S];
        tw[0] = 32'h0000_0001; tw[1] = 32'h0003_0002; tw[2] = 32'h0004_0000; tw[3] = 32'h0000_0000;
        tn[0] = 32'h0000_0005; tn[1] = 32'h0006_0007; tn[2] = 32'h0008_0000; tn[3] = 32'h0000_0000;
        set_basic();
        model_job();
        load_job(0, 0);
        run_stream(NCYC);
        for (int k = 0; k < S; k++) begin
            vectors++;
            if (obs[k] !== {tw[k], tn[k], 3'b100}) begin
                miscompares++;
                $display("FAIL basic_table t%0d got %h exp %h", k, obs[k], {tw[k], tn[k], 3'b100});
            end
        end
        vectors++; if (obs[S][1] !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b exp 1", obs[S][1]); end
        for (int i = 0; i < NCYC; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL basic cyc%0d got %h exp %h", i, obs[i], expv[i]); end
        end
    endtask

    task automatic test_gaps();
        set_basic();
        model_job();
        load_job(3, 1);   // bubbles, and in_valid left high with junk during STREAM
        run_stream(NCYC);
        for (int i = 0; i < NCYC; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL gaps cyc%0d got %h exp %h", i, obs[i], expv[i]); end
        end
    endtask

    task automatic test_hold();
        set_basic();
        hold_pat[2] = 1'b1; hold_pat[3] = 1'b1;
        model_job();
        load_job(0, 0);
        run_stream(NCYC);
        vectors++; if (obs[3] !== {32'h0003_0002, 32'h0006_0007, 3'b000}) begin miscompares++; $display("FAIL hold_held got %h", obs[3]); end
        vectors++; if (obs[S+2][1] !== 1'b1) begin miscompares++; $display("FAIL hold_done_late got %b exp 1", obs[S+2][1]); end
        for (int i = 0; i < NCYC; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL hold cyc%0d got %h exp %h", i, obs[i], expv[i]); end
        end
    endtask

    task automatic test_reset_mid();
        set_basic();
        load_job(0, 0);
        run_stream(3);   // t2 now on the lanes
        rst = 1'b1;
        #1;
        vectors++;
        if ({west_out, north_out, mxu_ce, done, in_ready} !== {{(2*N*G+2){1'b0}}, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid got %h exp 1", {west_out, north_out, mxu_ce, done, in_ready});
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        // One stray beat, then reset: it must be forgotten.
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'hCAFE_F00D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        model_job();
        load_job(0, 0);
        run_stream(NCYC);
        for (int i = 0; i < NCYC; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL reset_mid_job cyc%0d got %h exp %h", i, obs[i], expv[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        set_basic();
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++) begin
                ma[r][c] = 16'hFFFF; mb[r][c] = 16'hFFFF;
            end
        model_job();
        load_job(0, 0);
        run_stream(S + 2);   // ends on the edge that reopens LOAD
        dones = 0;
        for (int i = 0; i < S + 2; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL b2b_ones cyc%0d got %h exp %h", i, obs[i], expv[i]); end
            if (obs[i][1]) dones++;
        end
        set_basic();
        ma[0][0] = 16'd1; ma[0][1] = 16'd0; ma[1][0] = 16'd0; ma[1][1] = 16'd1;
        mb[0][0] = 16'd9; mb[0][1] = 16'd10; mb[1][0] = 16'd11; mb[1][1] = 16'd12;
        model_job();
        load_job(0, 0);
        run_stream(NCYC);
        for (int i = 0; i < NCYC; i++) begin
            vectors++;
            if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL b2b_ident cyc%0d got %h exp %h", i, obs[i], expv[i]); end
            if (obs[i][1]) dones++;
        end
        vectors++; if (dones !== 2) begin miscompares++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < G; r++)
                for (int c = 0; c < G; c++) begin
                    ma[r][c] = N'($urandom); mb[r][c] = N'($urandom);
                end
            for (int i = 0; i < NCYC; i++) hold_pat[i] = (i < 8) && ($urandom_range(3, 0) == 0);
            model_job();
            load_job(2, it[0]);
            run_stream(NCYC);
            for (int i = 0; i < NCYC; i++) begin
                vectors++;
                if (obs[i] !== expv[i]) begin miscompares++; $display("FAIL random it%0d cyc%0d got %h exp %h", it, i, obs[i], expv[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_a = '0; in_b = '0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_gaps();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
